// File: rtl/pacman_mover.sv
// -----------------------------------------------------------------------------
// pacman_mover
// Player-side movement engine. Samples the four direction buttons, runs a
// speed-scaled step accumulator off a free-running tick divider, and on each
// step queries the maze wall responder (req/ack) before moving one tile,
// turning, wrapping through the tunnel, or stalling against a wall.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   enable                          movement enable (ticks ignored when low)
//   btnUp/btnDown/btnLeft/btnRight  level-sensitive buttons (Up > Down > Left > Right)
//   wall_req, wall_x, wall_y        wall query request and tile being queried
//   wall_ack                        one-cycle ack; wall bits valid in that cycle
//   wallUp/wallDown/wallLeft/wallRight  walls around (wall_x, wall_y)
//   pacmanX, pacmanY, pacmanDir     current tile and heading (UP=00 DOWN=01 LEFT=10 RIGHT=11)
//   step_pulse                      one-cycle pulse when the position changes
//   stalled                         high while blocked by a wall
//
// Build option: define PACMAN_TURN_BUFFER_EN to keep a one-deep turn request
// that persists until consumed; otherwise DECIDE uses the live buttons.
// -----------------------------------------------------------------------------
module pacman_mover #(
    parameter int START_X     = 13,
    parameter int START_Y     = 26,
    parameter int MOVE_DIV    = 416666,
    parameter int SPEED       = 160,
    parameter int ACC_MAX     = 1000,
    parameter int MAX_X       = 27,
    parameter int TUNNEL_Y    = 19,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnLeft,
    input  logic       btnRight,
    output logic       wall_req,
    output logic [5:0] wall_x,
    output logic [5:0] wall_y,
    input  logic       wall_ack,
    input  logic       wallUp,
    input  logic       wallDown,
    input  logic       wallLeft,
    input  logic       wallRight,
    output logic [5:0] pacmanX,
    output logic [5:0] pacmanY,
    output logic [1:0] pacmanDir,
    output logic       step_pulse,
    output logic       stalled
);

    // state  | meaning
    // IDLE   | waiting for an accepted tick to overflow the accumulator
    // QUERY  | wall_req held with the current tile; waiting for ack or timeout
    // DECIDE | one cycle: pick turn / straight / stall from the latched walls
    typedef enum logic [1:0] {IDLE = 2'd0, QUERY = 2'd1, DECIDE = 2'd2} state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [5:0] MAX_X_V    = 6'(MAX_X);
    localparam logic [5:0] TUNNEL_Y_V = 6'(TUNNEL_Y);

    // Tunnel ends count as open; the top row and left edge off the tunnel
    // row are hard boundaries regardless of the responder.
    function automatic logic dir_open(input logic [1:0] d, input logic [5:0] x,
                                      input logic [5:0] y, input logic [3:0] w);
        logic open_v;
        open_v = !w[d];
        if (d == DIR_LEFT && x == 6'd0)
            open_v = (y == TUNNEL_Y_V);
        else if (d == DIR_RIGHT && x == MAX_X_V && y == TUNNEL_Y_V)
            open_v = 1'b1;
        else if (d == DIR_UP && y == 6'd0)
            open_v = 1'b0;
        return open_v;
    endfunction

    function automatic logic [11:0] step_pos(input logic [1:0] d, input logic [5:0] x,
                                             input logic [5:0] y);
        logic [5:0] nx;
        logic [5:0] ny;
        nx = x;
        ny = y;
        case (d)
            DIR_UP:    ny = y - 6'd1;
            DIR_DOWN:  ny = y + 6'd1;
            DIR_LEFT:  nx = (x == 6'd0) ? MAX_X_V : x - 6'd1;
            default:   nx = (x == MAX_X_V) ? 6'd0 : x + 6'd1;
        endcase
        return {nx, ny};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] acc_q, acc_d, acc_next;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  walls_q, walls_d;
    logic        wall_req_q, wall_req_d;
    logic [5:0]  wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    logic [5:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]  dir_q, dir_d;
    logic        step_q, step_d;
    logic        stalled_q, stalled_d;
`ifdef PACMAN_TURN_BUFFER_EN
    logic        req_valid_q, req_valid_d;
    logic [1:0]  req_dir_q, req_dir_d;
`endif

    logic        tick;
    logic        btn_any;
    logic [1:0]  btn_dir;
    logic        cand_valid, take_req, fwd_open;
    logic [1:0]  cand_dir, move_dir;
    logic [11:0] next_pos;

    assign tick = (tick_cnt_q == 32'(MOVE_DIV));

    always_comb begin
        btn_any = btnUp | btnDown | btnLeft | btnRight;
        if (btnUp)         btn_dir = DIR_UP;
        else if (btnDown)  btn_dir = DIR_DOWN;
        else if (btnLeft)  btn_dir = DIR_LEFT;
        else               btn_dir = DIR_RIGHT;
    end

    always_comb begin
`ifdef PACMAN_TURN_BUFFER_EN
        cand_valid = req_valid_q;
        cand_dir   = req_dir_q;
`else
        cand_valid = btn_any;
        cand_dir   = btn_dir;
`endif
        take_req = cand_valid && dir_open(cand_dir, pos_x_q, pos_y_q, walls_q);
        fwd_open = dir_open(dir_q, pos_x_q, pos_y_q, walls_q);
        move_dir = take_req ? cand_dir : dir_q;
        next_pos = step_pos(move_dir, pos_x_q, pos_y_q);
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? 32'd0 : tick_cnt_q + 32'd1;
        acc_next   = acc_q + 16'(SPEED);
        acc_d      = acc_q;
        tmo_d      = tmo_q;
        walls_d    = walls_q;
        wall_req_d = wall_req_q;
        wall_x_d   = wall_x_q;
        wall_y_d   = wall_y_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        stalled_d  = stalled_q;
`ifdef PACMAN_TURN_BUFFER_EN
        req_valid_d = req_valid_q;
        req_dir_d   = req_dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    if (acc_next >= 16'(ACC_MAX)) begin
                        acc_d      = acc_next - 16'(ACC_MAX);
                        state_d    = QUERY;
                        wall_req_d = 1'b1;
                        wall_x_d   = pos_x_q;
                        wall_y_d   = pos_y_q;
                        tmo_d      = 16'(ACK_TIMEOUT - 1);
                    end else begin
                        acc_d = acc_next;
                    end
                end
            end
            QUERY: begin
                if (wall_ack) begin
                    walls_d    = {wallRight, wallLeft, wallDown, wallUp};
                    wall_req_d = 1'b0;
                    state_d    = DECIDE;
                end else if (tmo_q == 16'd0) begin
                    wall_req_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            DECIDE: begin
                state_d = IDLE;
                if (take_req || fwd_open) begin
                    pos_x_d   = next_pos[11:6];
                    pos_y_d   = next_pos[5:0];
                    dir_d     = move_dir;
                    step_d    = 1'b1;
                    stalled_d = 1'b0;
`ifdef PACMAN_TURN_BUFFER_EN
                    if (take_req) req_valid_d = 1'b0;
`endif
                end else begin
                    stalled_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PACMAN_TURN_BUFFER_EN
        // A press in the same cycle as consumption wins over the clear.
        if (btn_any) begin
            req_valid_d = 1'b1;
            req_dir_d   = btn_dir;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= 32'd0;
            acc_q      <= 16'd0;
            tmo_q      <= 16'd0;
            walls_q    <= 4'd0;
            wall_req_q <= 1'b0;
            wall_x_q   <= 6'd0;
            wall_y_q   <= 6'd0;
            pos_x_q    <= 6'(START_X);
            pos_y_q    <= 6'(START_Y);
            dir_q      <= DIR_LEFT;
            step_q     <= 1'b0;
            stalled_q  <= 1'b0;
`ifdef PACMAN_TURN_BUFFER_EN
            req_valid_q <= 1'b0;
            req_dir_q   <= DIR_UP;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            acc_q      <= acc_d;
            tmo_q      <= tmo_d;
            walls_q    <= walls_d;
            wall_req_q <= wall_req_d;
            wall_x_q   <= wall_x_d;
            wall_y_q   <= wall_y_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            stalled_q  <= stalled_d;
`ifdef PACMAN_TURN_BUFFER_EN
            req_valid_q <= req_valid_d;
            req_dir_q   <= req_dir_d;
`endif
        end
    end

    assign wall_req   = wall_req_q;
    assign wall_x     = wall_x_q;
    assign wall_y     = wall_y_q;
    assign pacmanX    = pos_x_q;
    assign pacmanY    = pos_y_q;
    assign pacmanDir  = dir_q;
    assign step_pulse = step_q;
    assign stalled    = stalled_q;

endmodule

// File: tb/tb_pacman_mover.sv
// -----------------------------------------------------------------------------
// tb_pacman_mover
// Bench for pacman_mover. A responder plays the maze wall block, chooses walls
// and buttons per query, and pushes the predicted outcome of each decision
// into a queue; a monitor pops and compares whenever the DUT shows a step or
// a new stall. Reset, tunnel, turn-request, timeout, enable and mid-handshake
// reset cases are driven as directed phases, followed by a randomized walk.
// -----------------------------------------------------------------------------
module tb_pacman_mover;
    localparam int START_X     = 13;
    localparam int START_Y     = 26;
    localparam int MAX_X       = 27;
    localparam int TUNNEL_Y    = 19;
    localparam int ACK_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] btns = 4'd0;      // {right, left, down, up}
    logic [3:0] walls = 4'd0;     // {right, left, down, up}
    logic       wall_ack = 1'b0;
    logic       wall_req;
    logic [5:0] wall_x, wall_y, pacmanX, pacmanY;
    logic [1:0] pacmanDir;
    logic       step_pulse, stalled;

    pacman_mover #(.MOVE_DIV(9), .SPEED(1000)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btnUp(btns[0]), .btnDown(btns[1]), .btnLeft(btns[2]), .btnRight(btns[3]),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y), .wall_ack(wall_ack),
        .wallUp(walls[0]), .wallDown(walls[1]), .wallLeft(walls[2]), .wallRight(walls[3]),
        .pacmanX(pacmanX), .pacmanY(pacmanY), .pacmanDir(pacmanDir),
        .step_pulse(step_pulse), .stalled(stalled)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: tile position, heading, stall flag, pending turn.
    typedef struct {int x; int y; int dir; bit moved; bit stl;} exp_t;
    exp_t exp_q[$];
    int m_x = START_X, m_y = START_Y, m_dir = 2;
    bit m_stalled = 0;
    bit m_rv = 0;
    int m_rd = 0;

    function automatic int prio(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return i;
        return 0;
    endfunction

    function automatic bit m_open(input int d, input int x, input int y, input logic [3:0] w);
        if (d == 2 && x == 0) return (y == TUNNEL_Y);
        if (d == 3 && x == MAX_X && y == TUNNEL_Y) return 1'b1;
        if (d == 0 && y == 0) return 1'b0;
        return !w[d];
    endfunction

    task automatic m_move(input int d);
        case (d)
            0: m_y = (m_y + 63) % 64;
            1: m_y = (m_y + 1) % 64;
            2: m_x = (m_x == 0) ? MAX_X : m_x - 1;
            default: m_x = (m_x == MAX_X) ? 0 : (m_x + 1) % 64;
        endcase
    endtask

    task automatic predict(input logic [3:0] w, input logic [3:0] b);
        bit cv;
        int cd;
        bit moved;
        exp_t e;
`ifdef PACMAN_TURN_BUFFER_EN
        cv = m_rv;
        cd = m_rd;
`else
        cv = (b != 4'd0);
        cd = prio(b);
`endif
        moved = 1'b1;
        if (cv && m_open(cd, m_x, m_y, w)) begin
            m_move(cd);
            m_dir = cd;
`ifdef PACMAN_TURN_BUFFER_EN
            m_rv = (b != 4'd0);
`endif
        end else if (m_open(m_dir, m_x, m_y, w)) begin
            m_move(m_dir);
        end else begin
            moved = 1'b0;
        end
        if (moved || !m_stalled) begin
            e.x = m_x; e.y = m_y; e.dir = m_dir; e.moved = moved; e.stl = !moved;
            exp_q.push_back(e);
        end
        m_stalled = !moved;
    endtask

    // Responder control: mode 0 random, 1 directed, 2 navigate to (0,TUNNEL_Y).
    int         mode = 1;
    logic [3:0] d_walls = 4'd0, d_btns = 4'd0, d_pulse = 4'd0;
    bit         d_noack = 0;
    int         n_queries = 0;
    bit         resp_off = 0, resp_busy = 0, pulse_on = 0;

    initial begin
        logic [3:0] w, b, pl;
        bit noack;
        int cnt;
        forever begin
            @(negedge clk);
            if (pulse_on) begin btns = 4'd0; pulse_on = 0; end
            if (resp_off || reset || !wall_req) continue;
            resp_busy = 1;
            check("query_x", int'(wall_x), m_x);
            check("query_y", int'(wall_y), m_y);
            if (mode == 0) begin
                w = {($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30),
                     ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 30)};
                b = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                pl = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'd0;
                noack = ($urandom_range(0, 99) < 15);
            end else if (mode == 2) begin
                w = 4'd0;
                b = (m_x != 0) ? 4'b0100 : (m_y > TUNNEL_Y) ? 4'b0001 : 4'b0010;
                pl = 4'd0;
                noack = 0;
            end else begin
                w = d_walls; b = d_btns; pl = d_pulse; noack = d_noack;
            end
            walls = w;
            btns = b;
`ifdef PACMAN_TURN_BUFFER_EN
            if (b != 4'd0) begin m_rv = 1; m_rd = prio(b); end
`endif
            if (!noack) begin
                @(negedge clk);
                @(negedge clk);
                wall_ack = 1'b1;
                predict(w, b);
                @(negedge clk);
                wall_ack = 1'b0;
                check("req_drop_after_ack", int'(wall_req), 0);
                @(negedge clk);
                btns = 4'd0;
                if (pl != 4'd0) begin
                    btns = pl;
                    pulse_on = 1;
`ifdef PACMAN_TURN_BUFFER_EN
                    m_rv = 1; m_rd = prio(pl);
`endif
                end
            end else begin
                cnt = 1;
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (!wall_req) break;
                    cnt++;
                end
                check("timeout_req_len", cnt, ACK_TIMEOUT);
                btns = 4'd0;
            end
            n_queries++;
            resp_busy = 0;
        end
    end

    // Monitor: any step or fresh stall is a DUT output event to score.
    initial begin
        bit prev_stl, prev_step;
        exp_t e;
        prev_stl = 0; prev_step = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_step) check("pulse_width", int'(step_pulse), 0);
                if (step_pulse || (stalled && !prev_stl)) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", int'(step_pulse), int'(!step_pulse));
                    end else begin
                        e = exp_q.pop_front();
                        check("ev_step", int'(step_pulse), int'(e.moved));
                        check("ev_x", int'(pacmanX), e.x);
                        check("ev_y", int'(pacmanY), e.y);
                        check("ev_dir", int'(pacmanDir), e.dir);
                        check("ev_stalled", int'(stalled), int'(e.stl));
                    end
                end
            end
            prev_stl = stalled;
            prev_step = step_pulse;
        end
    end

    task automatic run_queries(input int n, input bit toggle_en);
        int target;
        int t;
        target = n_queries + n;
        t = 0;
        while (n_queries < target && t < n * 80) begin
            @(posedge clk); #1;
            t++;
            if (toggle_en && $urandom_range(0, 3) == 0) enable = ~enable;
        end
        check("query_progress", int'(n_queries >= target), 1);
    endtask

    initial begin
        int t, seen;
        mode = 1; d_walls = 4'b0100; d_btns = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", int'(pacmanX), START_X);
        check("rst_y", int'(pacmanY), START_Y);
        check("rst_dir", int'(pacmanDir), 2);
        check("rst_req", int'(wall_req), 0);
        check("rst_wall_xy", int'({wall_x, wall_y}), 0);
        check("rst_step", int'(step_pulse), 0);
        check("rst_stalled", int'(stalled), 0);
        reset = 1'b0;
        enable = 1'b1;

        // Wall ahead, no buttons: stall in place.
        run_queries(3, 0);
        check("stall_x", int'(pacmanX), 13);
        check("stall_flag", int'(stalled), 1);

        // Open corridor: 13 -> 10.
        d_walls = 4'd0;
        run_queries(3, 0);
        check("corridor_x", int'(pacmanX), 10);
        check("corridor_stalled", int'(stalled), 0);

        // One-cycle UP press while UP is walled for two steps.
        d_walls = 4'b0001; d_pulse = 4'b0001;
        run_queries(1, 0);
        d_pulse = 4'd0;
        run_queries(1, 0);
        check("preturn_x", int'(pacmanX), 8);
        d_walls = 4'd0;
        run_queries(1, 0);
`ifdef PACMAN_TURN_BUFFER_EN
        check("turn_dir", int'(pacmanDir), 0);
        check("turn_y", int'(pacmanY), 25);
`else
        check("turn_dir", int'(pacmanDir), 2);
        check("turn_x", int'(pacmanX), 7);
`endif

        // Walk to the tunnel mouth, then wrap both ways.
        mode = 2;
        t = 0;
        while (!(m_x == 0 && m_y == TUNNEL_Y) && t < 60) begin
            run_queries(1, 0);
            t++;
        end
        check("nav_reached", int'(pacmanX == 6'd0 && pacmanY == 6'(TUNNEL_Y)), 1);
        mode = 1; d_walls = 4'b0100; d_btns = 4'b0100;
        run_queries(1, 0);
        check("tunnel_left_x", int'(pacmanX), MAX_X);
        check("tunnel_left_y", int'(pacmanY), TUNNEL_Y);
        d_walls = 4'b1000; d_btns = 4'b1000;
        run_queries(1, 0);
        check("tunnel_right_x", int'(pacmanX), 0);
        d_walls = 4'd0; d_btns = 4'd0;

        // Enable low: no further queries.
        enable = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (wall_req) seen++;
        end
        check("enable_low_no_req", seen, 0);

        // Unanswered queries: abandon, no move, re-query on next tick.
        enable = 1'b1;
        d_noack = 1;
        run_queries(2, 0);
        check("timeout_x", int'(pacmanX), m_x);
        check("timeout_y", int'(pacmanY), m_y);
        d_noack = 0;

        // Randomized walk with random walls, buttons, enable and lost acks.
        mode = 0;
        run_queries(60, 1);
        enable = 1'b1;
        mode = 1; d_walls = 4'd0; d_btns = 4'd0; d_pulse = 4'd0;

        // Reset in the middle of a handshake.
        t = 0;
        while (resp_busy && t < 100) begin @(posedge clk); #1; t++; end
        resp_off = 1;
        t = 0;
        while (!wall_req && t < 100) begin @(posedge clk); #1; t++; end
        check("mid_req_seen", int'(wall_req), 1);
        check("queue_drained", exp_q.size(), 0);
        reset = 1'b1;
        #1;
        check("mid_rst_req", int'(wall_req), 0);
        check("mid_rst_x", int'(pacmanX), START_X);
        check("mid_rst_y", int'(pacmanY), START_Y);
        check("mid_rst_dir", int'(pacmanDir), 2);
        m_x = START_X; m_y = START_Y; m_dir = 2; m_stalled = 0; m_rv = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        resp_off = 0;
        run_queries(1, 0);
        check("post_rst_x", int'(pacmanX), START_X - 1);

        repeat (5) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
